fp_addsub_seq: RTL and testbench
================================

Name: fp_addsub_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor with a start/done handshake.
- Generalises the first-generation single-precision add block:
  - configurable exponent and mantissa widths
  - runtime add/sub mode
  - exponent alignment, normalisation and round-to-nearest-even
  - special-value handling, with overflow and underflow flags
- Sits between the operand register file and the result writeback in the FP datapath.
- One operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit not stored).
- Derived: W = 1+EXP_W+MAN_W (default 32).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- add_start  in  1  start request, sampled in IDLE only.
- mode  in  1  0 = op1+op2, 1 = op1-op2; captured with operands.
- op1  in  W  operand A: {sign, exp, frac}.
- op2  in  W  operand B.
- add_result  out  W  result; valid when add_done=1, held until next capture.
- add_done  out  1  one-cycle pulse, result ready.
- add_busy  out  1  high from capture through the ROUND cycle.
- add_overflow  out  1  result overflowed to ±inf; valid with add_done, held with result.
- add_underflow  out  1  result flushed to ±0; valid with add_done, held with result.

Behaviour:
- Reset: synchronous, active-high, one clock. Forces state to IDLE and clears every output: add_result=0, add_done=0, add_busy=0, add_overflow=0, add_underflow=0.
- Reset mid-operation aborts the operation; no done pulse is produced for it.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
  - IDLE with add_start=1 at edge E0: captures op1, op2 and mode (op2 sign inverted when mode=1); sets busy.
  - ALIGN (edge E1):
    - Unpack; exp==0 is treated as ±0 (denormal inputs flushed).
    - Swap so the larger magnitude is A.
    - Right-shift B's significand by the exponent difference into a MAN_W+4-bit field (hidden + frac + guard/round/sticky).
    - Shifted-out bits are ORed into sticky; a shift >= MAN_W+3 leaves only sticky.
  - ADD (edge E2): same effective sign -> add; different -> subtract (A-B, never negative). One carry bit is retained.
  - NORM (edge E3):
    - On carry: shift right 1, exp+1, sticky accumulates.
    - Otherwise: single-cycle leading-zero count and left shift, exp minus count.
  - ROUND (edge E4):
    - Round-to-nearest-even on guard/round/sticky. A mantissa carry-out from rounding renormalises and increments exp.
    - Registers add_result and flags, pulses add_done for exactly one cycle, clears busy.
- Latency: fixed. add_done is high in the cycle following E4, i.e. 4 cycles after the capture edge, independent of operands.
- add_start:
  - Ignored while busy.
  - Accepted in the same cycle add_done is high (state is IDLE), giving back-to-back throughput of one op per 5 cycles.
- Overflow: final exp >= 2^EXP_W-1 (finite inputs) -> ±inf (frac 0), add_overflow=1.
- Underflow: final exp <= 0 -> ±0 with the computed sign, add_underflow=1.
- Exact zero result (e.g. x-x): +0, except (-0)+(-0) -> -0. Neither flag is set.
- Specials are decided from the captured operands; the pipeline still takes full latency:
  - Any NaN operand -> canonical NaN: sign 0, exp all ones, frac MSB 1 (0x7FC00000 at default).
  - inf + (-inf) -> canonical NaN.
  - inf with finite -> that inf.
  - No flags are set for any special result.
- Flags clear at each new capture.

Test Plan:
- 0x3FA00000 (1.25) + 0x3FC00000 (1.5), mode=0 -> add_result=0x40300000 (2.75), done 4 cycles after capture, flags 0.
- 0x3FC00000 - 0x3FA00000, mode=1 -> 0x3E800000 (0.25); exercises a 2-position left normalise.
- Rounding: 0x3F800000 + 0x33800000 (tie) -> 0x3F800000. 0x3F800000 + 0x33800001 -> 0x3F800001.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, add_overflow=1. Also 0x40490FDB - 0x40490FDB -> 0x00000000, no flags.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Handshake:
  - add_start held high continuously -> one done pulse every 5 cycles.
  - rst asserted during NORM -> next cycle all outputs 0, no done pulse.
  - EXP_W=5, MAN_W=10 instance: 0x3C00 + 0x3C00 -> 0x4000.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style floating-point adder/subtractor with start/done handshake.
// One operation in flight: IDLE -> ALIGN -> ADD -> NORM -> ROUND, fixed latency.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   add_start,
  input  logic                   mode,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic [EXP_W+MAN_W:0]   add_result,
  output logic                   add_done,
  output logic                   add_busy,
  output logic                   add_overflow,
  output logic                   add_underflow
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4
  } state_t;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) begin
        n = LZW'(SW - 1 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Right shift that folds every discarded bit into the sticky position (bit 0).
  function automatic logic [SW-1:0] shr_sticky(input logic [SW-1:0] v, input logic [EXP_W-1:0] d);
    logic [SW-1:0] mask;
    logic [SW-1:0] r;
    if (32'(d) >= 32'(MAN_W + 3)) begin
      r = {{(SW-1){1'b0}}, |v};
    end else begin
      mask = ~({SW{1'b1}} << d);
      r    = v >> d;
      r[0] = r[0] | (|(v & mask));
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [SW-1:0]   siga_q, siga_d, sigb_q, sigb_d;
  logic [SW:0]     sum_q, sum_d;
  logic [SW-1:0]   man_q, man_d;
  logic            zero_q, zero_d, spec_q, spec_d;
  logic [W-1:0]    spec_res_q, spec_res_d;
  logic [W-1:0]    result_q, result_d;
  logic            done_q, done_d, busy_q, busy_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [EXP_W-1:0] ea_c, eb_c, big_e_c, sml_e_c;
  logic [MAN_W-1:0] fa_c, fb_c, big_f_c, sml_f_c;
  logic             sa_c, sb_c, a_zero_c, b_zero_c, a_nan_c, b_nan_c, a_inf_c, b_inf_c;
  logic             swap_c, big_s_c, big_zero_c, sml_zero_c, spec_hit_c;
  logic [SW-1:0]    sig_big_c, sig_sml_c, aligned_c;
  logic [W-1:0]     spec_val_c;
  logic [SW:0]      sum_c;
  logic [LZW-1:0]   lz_c;
  logic [SW-1:0]    norm_man_c;
  logic [EW-1:0]    norm_exp_c;
  logic             round_up_c, ovf_c, unf_c;
  logic [MAN_W+1:0] mant_c;
  logic [EW-1:0]    exp_r_c;
  logic [MAN_W-1:0] frac_r_c;

  // Datapath for every stage, evaluated from the registered stage state.
  always_comb begin
    sa_c     = a_q[W-1];
    sb_c     = b_q[W-1];
    ea_c     = a_q[W-2:MAN_W];
    eb_c     = b_q[W-2:MAN_W];
    a_zero_c = (ea_c == {EXP_W{1'b0}});
    b_zero_c = (eb_c == {EXP_W{1'b0}});
    a_nan_c  = (ea_c == EXP_ONES) && (a_q[MAN_W-1:0] != {MAN_W{1'b0}});
    b_nan_c  = (eb_c == EXP_ONES) && (b_q[MAN_W-1:0] != {MAN_W{1'b0}});
    a_inf_c  = (ea_c == EXP_ONES) && (a_q[MAN_W-1:0] == {MAN_W{1'b0}});
    b_inf_c  = (eb_c == EXP_ONES) && (b_q[MAN_W-1:0] == {MAN_W{1'b0}});
    fa_c     = a_zero_c ? {MAN_W{1'b0}} : a_q[MAN_W-1:0];
    fb_c     = b_zero_c ? {MAN_W{1'b0}} : b_q[MAN_W-1:0];

    swap_c     = {eb_c, fb_c} > {ea_c, fa_c};
    big_s_c    = swap_c ? sb_c : sa_c;
    big_e_c    = swap_c ? eb_c : ea_c;
    big_f_c    = swap_c ? fb_c : fa_c;
    big_zero_c = swap_c ? b_zero_c : a_zero_c;
    sml_e_c    = swap_c ? ea_c : eb_c;
    sml_f_c    = swap_c ? fa_c : fb_c;
    sml_zero_c = swap_c ? a_zero_c : b_zero_c;
    sig_big_c  = big_zero_c ? {SW{1'b0}} : {1'b1, big_f_c, 3'b000};
    sig_sml_c  = sml_zero_c ? {SW{1'b0}} : {1'b1, sml_f_c, 3'b000};
    aligned_c  = shr_sticky(sig_sml_c, big_e_c - sml_e_c);

    spec_hit_c = a_nan_c | b_nan_c | a_inf_c | b_inf_c;
    if (a_nan_c || b_nan_c || (a_inf_c && b_inf_c && (sa_c != sb_c))) begin
      spec_val_c = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (a_inf_c) begin
      spec_val_c = {sa_c, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      spec_val_c = {sb_c, EXP_ONES, {MAN_W{1'b0}}};
    end

    sum_c = eff_sub_q ? ({1'b0, siga_q} - {1'b0, sigb_q}) : ({1'b0, siga_q} + {1'b0, sigb_q});

    lz_c = lzc(sum_q[SW-1:0]);
    if (sum_q[SW]) begin
      norm_man_c = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      norm_exp_c = exp_q + {{(EW-1){1'b0}}, 1'b1};
    end else begin
      norm_man_c = sum_q[SW-1:0] << lz_c;
      norm_exp_c = exp_q - EW'(lz_c);
    end

    // Nearest-even: guard set and (round | sticky | lsb) rounds up.
    round_up_c = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    mant_c     = {1'b0, man_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up_c};
    exp_r_c    = exp_q + {{(EW-1){1'b0}}, mant_c[MAN_W+1]};
    frac_r_c   = mant_c[MAN_W+1] ? mant_c[MAN_W:1] : mant_c[MAN_W-1:0];
    unf_c      = exp_r_c[EW-1] | (exp_r_c == {EW{1'b0}});
    ovf_c      = !exp_r_c[EW-1] && (exp_r_c >= {2'b00, EXP_ONES});
  end

  // Next-state and register-update selection for the control FSM.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    siga_d     = siga_q;
    sigb_d     = sigb_q;
    sum_d      = sum_q;
    man_d      = man_q;
    zero_d     = zero_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    case (state_q)
      S_IDLE: begin
        if (add_start) begin
          a_d     = op1;
          b_d     = {op2[W-1] ^ mode, op2[W-2:0]};
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_ALIGN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ALIGN: begin
        siga_d     = sig_big_c;
        sigb_d     = aligned_c;
        exp_d      = {2'b00, big_e_c};
        sign_d     = big_s_c;
        eff_sub_d  = sa_c ^ sb_c;
        spec_d     = spec_hit_c;
        spec_res_d = spec_val_c;
        state_d    = S_ADD;
      end
      S_ADD: begin
        sum_d   = sum_c;
        state_d = S_NORM;
      end
      S_NORM: begin
        man_d   = norm_man_c;
        exp_d   = norm_exp_c;
        zero_d  = (sum_q == {(SW+1){1'b0}});
        state_d = S_ROUND;
      end
      S_ROUND: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (spec_q) begin
          result_d = spec_res_q;
        end else if (zero_q) begin
          result_d = {sign_q & ~eff_sub_q, {(W-1){1'b0}}};
        end else if (ovf_c) begin
          result_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          ovf_d    = 1'b1;
        end else if (unf_c) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_r_c[EXP_W-1:0], frac_r_c};
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= {W{1'b0}};
      b_q        <= {W{1'b0}};
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= {EW{1'b0}};
      siga_q     <= {SW{1'b0}};
      sigb_q     <= {SW{1'b0}};
      sum_q      <= {(SW+1){1'b0}};
      man_q      <= {SW{1'b0}};
      zero_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= {W{1'b0}};
      result_q   <= {W{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      exp_q      <= exp_d;
      siga_q     <= siga_d;
      sigb_q     <= sigb_d;
      sum_q      <= sum_d;
      man_q      <= man_d;
      zero_q     <= zero_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign add_result    = result_q;
  assign add_done      = done_q;
  assign add_busy      = busy_q;
  assign add_overflow  = ovf_q;
  assign add_underflow = unf_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq: single and half precision instances,
// arithmetic, rounding, specials, latency, back-to-back throughput and mid-op reset.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        add_start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] op1 = 32'h0, op2 = 32'h0;
  logic [31:0] add_result;
  logic        add_done, add_busy, add_overflow, add_underflow;

  logic        h_start = 1'b0;
  logic        h_mode = 1'b0;
  logic [15:0] h_op1 = 16'h0, h_op2 = 16'h0;
  logic [15:0] h_result;
  logic        h_done, h_busy, h_ovf, h_unf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .add_start(add_start), .mode(mode),
    .op1(op1), .op2(op2), .add_result(add_result), .add_done(add_done),
    .add_busy(add_busy), .add_overflow(add_overflow), .add_underflow(add_underflow)
  );

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .add_start(h_start), .mode(h_mode),
    .op1(h_op1), .op2(h_op2), .add_result(h_result), .add_done(h_done),
    .add_busy(h_busy), .add_overflow(h_ovf), .add_underflow(h_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation and check the busy window, the exact done cycle and the result.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic m, input logic [31:0] er, input logic eo, input logic eu);
    @(negedge clk);
    op1 = x; op2 = y; mode = m; add_start = 1'b1;
    @(posedge clk); #1;
    add_start = 1'b0;
    check({tag, "_busy"}, {31'b0, add_busy}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_early_done"}, {31'b0, add_done}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, {31'b0, add_done}, 32'd1);
    check({tag, "_result"}, add_result, er);
    check({tag, "_ovf"}, {31'b0, add_overflow}, {31'b0, eo});
    check({tag, "_unf"}, {31'b0, add_underflow}, {31'b0, eu});
    check({tag, "_busy_clr"}, {31'b0, add_busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'b0, add_done}, 32'd0);
  endtask

  initial begin
    int dones;
    int first_idx;
    int last_idx;

    repeat (2) @(posedge clk);
    #1;
    check("rst_result", add_result, 32'h0);
    check("rst_flags", {28'b0, add_done, add_busy, add_overflow, add_underflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_basic", 32'h3FA00000, 32'h3FC00000, 1'b0, 32'h40300000, 1'b0, 1'b0);
    run_op("sub_norm2", 32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 1'b0);
    run_op("rnd_tie",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_op("rnd_up",    32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
    run_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    run_op("x_minus_x", 32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 1'b0, 1'b0);
    run_op("inf_ninf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
    run_op("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
    run_op("inf_fin",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
    run_op("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
    run_op("unf",       32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1);
    run_op("neg_add",   32'hBFA00000, 32'hBFC00000, 1'b0, 32'hC0300000, 1'b0, 1'b0);

    // add_start held high: captures every 5 cycles, done at indices 4,9,14,19,24.
    @(negedge clk);
    op1 = 32'h3FA00000; op2 = 32'h3FC00000; mode = 1'b0; add_start = 1'b1;
    dones = 0; first_idx = -1; last_idx = -1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (add_done) begin
        dones++;
        if (first_idx < 0) first_idx = i;
        if (last_idx >= 0) check("b2b_interval", i - last_idx, 32'd5);
        check("b2b_result", add_result, 32'h40300000);
        last_idx = i;
      end
    end
    @(negedge clk);
    add_start = 1'b0;
    check("b2b_count", dones, 32'd5);
    check("b2b_first", first_idx, 32'd4);
    repeat (6) @(posedge clk);

    // Reset while the FSM is in NORM: outputs clear next cycle and no done follows.
    @(negedge clk);
    op1 = 32'h7F7FFFFF; op2 = 32'h7F7FFFFF; mode = 1'b0; add_start = 1'b1;
    @(posedge clk); #1;
    add_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_result", add_result, 32'h0);
    check("midrst_flags", {28'b0, add_done, add_busy, add_overflow, add_underflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (add_done) dones++;
    end
    check("midrst_no_done", dones, 32'd0);
    run_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);

    // Half-precision instance.
    @(negedge clk);
    h_op1 = 16'h3C00; h_op2 = 16'h3C00; h_mode = 1'b0; h_start = 1'b1;
    @(posedge clk); #1;
    h_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("half_done", {31'b0, h_done}, 32'd1);
    check("half_result", {16'b0, h_result}, 32'h00004000);
    check("half_flags", {30'b0, h_ovf, h_unf}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
